// File: rtl/uart_cmd_sender.sv
// Host-side UART command engine for the bus bridge: serializes read/write commands
// as 8N1 bytes on tx and collects the 4-byte read response from rx.
module uart_cmd_sender #(
    parameter int unsigned INPUT_CLOCK  = 50000000,
    parameter int unsigned UART_BAUD    = 9600,
    parameter int unsigned GAP_BITS     = 1,
    parameter int unsigned TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        tx,
    input  logic        rx,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned CLOCKS_BETWEEN_BITS = INPUT_CLOCK / UART_BAUD;
    localparam int unsigned TIMEOUT_CYCLES      = TIMEOUT_BITS * CLOCKS_BETWEEN_BITS;
    localparam int unsigned BW = (CLOCKS_BETWEEN_BITS > 2) ? $clog2(CLOCKS_BETWEEN_BITS) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GW = (GAP_BITS > 2) ? $clog2(GAP_BITS) : 1;

    localparam logic [BW-1:0] BIT_RELOAD  = BW'(CLOCKS_BETWEEN_BITS - 1);
    localparam logic [BW-1:0] HALF_RELOAD = BW'(CLOCKS_BETWEEN_BITS / 2 - 1);
    localparam logic [TW-1:0] TO_RELOAD   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_RELOAD  = GW'(GAP_BITS - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_TX_START = 4'd1;
    localparam logic [3:0] S_TX_DATA  = 4'd2;
    localparam logic [3:0] S_TX_STOP  = 4'd3;
    localparam logic [3:0] S_TX_GAP   = 4'd4;
    localparam logic [3:0] S_RX_WAIT  = 4'd5;
    localparam logic [3:0] S_RX_DATA  = 4'd6;
    localparam logic [3:0] S_RX_STOP  = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    logic [3:0]    r_state;
    logic [BW-1:0] r_bit_cnt;
    logic [2:0]    r_bit_idx;
    logic [3:0]    r_byte_idx;
    logic [GW-1:0] r_gap_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          r_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic [7:0]    r_shift;
    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_prev;
    logic          r_started;
    logic          r_tx;
    logic          r_cmd_ready;
    logic          r_busy;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_data;
    logic          r_rsp_err;

    logic [7:0]    w_tx_byte;
    logic          w_last_byte;
    logic          w_bit_done;
    logic          w_rx_fall;

    always_comb begin
        w_tx_byte = '0;
        case (r_byte_idx)
            4'd0:    w_tx_byte = r_write ? 8'h56 : 8'h55;
            4'd1:    w_tx_byte = r_addr[7:0];
            4'd2:    w_tx_byte = r_addr[15:8];
            4'd3:    w_tx_byte = r_addr[23:16];
            4'd4:    w_tx_byte = r_addr[31:24];
            4'd5:    w_tx_byte = r_data[7:0];
            4'd6:    w_tx_byte = r_data[15:8];
            4'd7:    w_tx_byte = r_data[23:16];
            4'd8:    w_tx_byte = r_data[31:24];
            default: w_tx_byte = '0;
        endcase
    end

    assign w_last_byte = r_write ? (r_byte_idx == 4'd8) : (r_byte_idx == 4'd4);
    assign w_bit_done  = (r_bit_cnt == '0);
    assign w_rx_fall   = r_rx_prev & ~r_rx_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_gap_cnt   <= '0;
            r_to_cnt    <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_shift     <= '0;
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_started   <= 1'b0;
            r_tx        <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rx_s1     <= rx;
            r_rx_s2     <= r_rx_s1;
            r_rx_prev   <= r_rx_s2;
            r_rsp_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_write     <= cmd_write;
                        r_addr      <= cmd_addr;
                        r_data      <= cmd_data;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                        r_byte_idx  <= '0;
                        r_tx        <= 1'b0;
                        r_bit_cnt   <= BIT_RELOAD;
                        r_state     <= S_TX_START;
                    end
                end

                S_TX_START: begin
                    if (w_bit_done) begin
                        r_tx      <= w_tx_byte[0];
                        r_shift   <= {1'b0, w_tx_byte[7:1]};
                        r_bit_idx <= '0;
                        r_bit_cnt <= BIT_RELOAD;
                        r_state   <= S_TX_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - BW'(1);
                    end
                end

                S_TX_DATA: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= BIT_RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_TX_STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - BW'(1);
                    end
                end

                S_TX_STOP: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= BIT_RELOAD;
                        if (w_last_byte) begin
                            if (r_write) begin
                                r_rsp_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_byte_idx <= '0;
                                r_to_cnt   <= TO_RELOAD;
                                r_started  <= 1'b0;
                                r_state    <= S_RX_WAIT;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                            if (GAP_BITS == 0) begin
                                r_tx    <= 1'b0;
                                r_state <= S_TX_START;
                            end else begin
                                r_gap_cnt <= GAP_RELOAD;
                                r_state   <= S_TX_GAP;
                            end
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - BW'(1);
                    end
                end

                S_TX_GAP: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= BIT_RELOAD;
                        if (r_gap_cnt == '0) begin
                            r_tx    <= 1'b0;
                            r_state <= S_TX_START;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - GW'(1);
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - BW'(1);
                    end
                end

                // Start-bit verification runs inside RX_WAIT so a rejected glitch
                // resumes the same, still-running timeout for this byte.
                S_RX_WAIT: begin
                    if (r_to_cnt != '0) begin
                        r_to_cnt <= r_to_cnt - TW'(1);
                    end
                    if (r_started) begin
                        if (w_bit_done) begin
                            r_started <= 1'b0;
                            if (!r_rx_s2) begin
                                r_bit_idx <= '0;
                                r_bit_cnt <= BIT_RELOAD;
                                r_state   <= S_RX_DATA;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt - BW'(1);
                        end
                    end else if (r_to_cnt == '0) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_rx_fall) begin
                        r_started <= 1'b1;
                        r_bit_cnt <= HALF_RELOAD;
                    end
                end

                S_RX_DATA: begin
                    if (w_bit_done) begin
                        r_shift   <= {r_rx_s2, r_shift[7:1]};
                        r_bit_cnt <= BIT_RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - BW'(1);
                    end
                end

                S_RX_STOP: begin
                    if (w_bit_done) begin
                        if (!r_rx_s2) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_rsp_data[{r_byte_idx[1:0], 3'b000} +: 8] <= r_shift;
                            if (r_byte_idx == 4'd3) begin
                                r_rsp_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_byte_idx <= r_byte_idx + 4'd1;
                                r_to_cnt   <= TO_RELOAD;
                                r_started  <= 1'b0;
                                r_state    <= S_RX_WAIT;
                            end
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - BW'(1);
                    end
                end

                S_DONE: begin
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign tx        = r_tx;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Randomized self-checking bench for uart_cmd_sender: decodes tx into bytes,
// answers reads on rx, and compares against a byte-level reference model.
module tb_uart_cmd_sender;

    localparam int BIT = 16;
    localparam int WR_LAT = (90 + 8) * BIT + 1;
    localparam int RD_TX_CYCLES = (50 + 4) * BIT;
    localparam int TO_LAT = RD_TX_CYCLES + 64 * BIT + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rx = 1'b1;
    logic        cmd_ready, tx, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mon_q[$];
    int         mon_start_q[$];
    int         mon_err_q[$];
    logic [7:0] exp_q[$];

    uart_cmd_sender #(
        .INPUT_CLOCK (153600),
        .UART_BAUD   (9600),
        .GAP_BITS    (1),
        .TIMEOUT_BITS(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .tx       (tx),
        .rx       (rx),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int cyc();
        return int'($time / 10);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // tx line decoder: every bit must be constant for BIT cycles
    initial begin : tx_mon
        int pos, bad, st;
        logic prev;
        logic [9:0] bits;
        pos = -1; prev = 1'b1; bad = 0; st = 0; bits = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pos = -1;
                prev = 1'b1;
            end else begin
                if (pos < 0 && prev && !tx) begin
                    pos = 0; bad = 0; st = cyc();
                end
                if (pos >= 0) begin
                    if (pos % BIT == 0) bits[pos / BIT] = tx;
                    else if (tx !== bits[pos / BIT]) bad++;
                    if (pos == 10 * BIT - 1) begin
                        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) bad++;
                        mon_q.push_back(bits[8:1]);
                        mon_start_q.push_back(st);
                        mon_err_q.push_back(bad);
                        pos = -1;
                    end else begin
                        pos++;
                    end
                end
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_mon();
        mon_q.delete(); mon_start_q.delete(); mon_err_q.delete();
    endtask

    task automatic build_exp(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_q.delete();
        exp_q.push_back(w ? 8'h56 : 8'h55);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'((a >> (8 * k)) & 32'hFF));
        if (w) for (int k = 0; k < 4; k++) exp_q.push_back(8'((d >> (8 * k)) & 32'hFF));
    endtask

    task automatic check_frame(input int acc);
        check("frame_nbytes", mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            check("tx_byte", mon_q[i], exp_q[i]);
            check("tx_bit_timing", mon_err_q[i], 0);
            if (i == 0) check("tx_first_start", mon_start_q[0] - acc, 1);
            else        check("tx_byte_spacing", mon_start_q[i] - mon_start_q[i-1], 11 * BIT);
        end
    endtask

    // Caller is at a negedge; returns the negedge cycle just before the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit hold, output int acc);
        cmd_write = w; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        acc = -1;
        for (int n = 0; n < 4000 && acc < 0; n++) begin
            if (cmd_ready) acc = cyc();
            else @(negedge clk);
        end
        if (acc < 0) begin
            check("accept_timeout", 0, 1);
            acc = cyc();
        end
        clear_mon();
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        check("acc_busy", busy, 1);
        check("acc_ready_low", cmd_ready, 0);
    endtask

    task automatic wait_rsp(input int budget, output int rc);
        rc = -1;
        for (int n = 0; n < budget && rc < 0; n++) begin
            @(negedge clk);
            if (rsp_valid) rc = cyc();
        end
        if (rc < 0) begin
            check("rsp_timeout", 0, 1);
            rc = cyc();
        end
        check("rsp_busy_incl", busy, 1);
    endtask

    task automatic after_rsp();
        @(negedge clk);
        check("rsp_one_cycle", rsp_valid, 0);
        check("busy_clear", busy, 0);
        check("ready_after_rsp", cmd_ready, 1);
    endtask

    task automatic run_write(input logic [31:0] a, input logic [31:0] d, input bit hold);
        int acc, rc, acc2, rc2;
        build_exp(1'b1, a, d);
        issue(1'b1, a, d, hold, acc);
        fork
            begin
                if (hold) begin
                    repeat (300) @(negedge clk);
                    rx = 1'b0;
                    repeat (4) @(negedge clk);
                    rx = 1'b1;
                end
            end
            wait_rsp(2500, rc);
        join
        check("wr_latency", rc - acc, WR_LAT);
        check("wr_rsp_data", rsp_data, 0);
        check("wr_rsp_err", rsp_err, 0);
        check_frame(acc);
        after_rsp();
        if (hold) begin
            acc2 = cyc();
            clear_mon();
            @(negedge clk);
            check("hold_reaccept_busy", busy, 1);
            check("hold_reaccept_ready", cmd_ready, 0);
            cmd_valid = 1'b0;
            wait_rsp(2500, rc2);
            check("hold2_latency", rc2 - acc2, WR_LAT);
            check("hold2_err", rsp_err, 0);
            check_frame(acc2);
            after_rsp();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    // bad_stop: index of the response byte sent with stop=0, or -1; silent: no reply
    task automatic run_read(input logic [31:0] a, input logic [31:0] resp,
                            input int bad_stop, input bit glitch, input bit silent);
        int acc, rc, n;
        logic [31:0] exp_data;
        logic        exp_err;
        build_exp(1'b0, a, 32'h0);
        issue(1'b0, a, $urandom, 1'b0, acc);
        n = 0;
        while (mon_q.size() < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_frame(acc);
        if (silent) begin
            wait_rsp(3000, rc);
            check("rd_timeout_latency", rc - acc, TO_LAT);
            check("rd_timeout_data", rsp_data, 0);
            check("rd_timeout_err", rsp_err, 1);
        end else begin
            exp_data = '0;
            exp_err  = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (k == bad_stop) begin
                    exp_err = 1'b1;
                    break;
                end
                exp_data = exp_data | (((resp >> (8 * k)) & 32'hFF) << (8 * k));
            end
            fork
                begin
                    repeat (BIT) @(negedge clk);
                    if (glitch) begin
                        rx = 1'b0;
                        repeat (4) @(negedge clk);
                        rx = 1'b1;
                        repeat (2 * BIT) @(negedge clk);
                    end
                    for (int k = 0; k < 4; k++) begin
                        send_byte(8'((resp >> (8 * k)) & 32'hFF), (k != bad_stop));
                        repeat (2 * BIT) @(negedge clk);
                    end
                end
                wait_rsp(3000, rc);
            join
            check("rd_rsp_data", rsp_data, exp_data);
            check("rd_rsp_err", rsp_err, exp_err);
        end
        after_rsp();
        repeat (5) @(negedge clk);
        check("rsp_data_hold", rsp_data, silent ? 32'h0 : exp_data);
    endtask

    initial begin : main
        int acc, seen;
        logic [31:0] a, d, r;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        #1 check("ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        check("ready_first_edge", cmd_ready, 1);

        // Reset 100 cycles into a write frame (tx is inside byte 0 bit 5, low)
        issue(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, acc);
        repeat (99) @(negedge clk);
        check("pre_reset_tx_low", tx, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", cmd_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);
        seen = 0;
        repeat (1700) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_rst", seen, 0);
        check("no_tx_after_rst", mon_q.size(), 0);

        // Directed cases from the plan
        run_write(32'h00000001, 32'h00FF00FF, 1'b0);
        run_read(32'h00000001, 32'h00FF00FF, -1, 1'b0, 1'b0);
        run_read($urandom, 32'h0, -1, 1'b0, 1'b1);
        run_read(32'hA5A5_0102, 32'h77335AFF, 2, 1'b0, 1'b0);
        run_write(32'hDEADBEEF, 32'h01234567, 1'b1);

        // Randomized commands
        for (int t = 0; t < 9; t++) begin
            a = $urandom;
            d = $urandom;
            r = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                run_write(a, d, 1'b0);
            end else begin
                seen = int'($urandom_range(0, 4));
                run_read(a, r, (seen == 4) ? -1 : seen, 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
